// File: rtl/alu_mdu.sv
// alu_mdu: RISC-V style integer ALU with an optional iterative multiply/divide unit.
// Define ALU_MDU_MULDIV_EN to build the shift-add multiplier / restoring divider.
module alu_mdu #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           funct7,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] source1,
  input  logic [WORD_SIZE-1:0] source2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] result,
  output logic                 illegal,
  output logic                 busy
);
  localparam int SHW = $clog2(WORD_SIZE);
  localparam int CW  = SHW + 1;
  // IDLE: can accept | ITER: mul/div stepping | HOLD: result waiting for out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 illegal_q, illegal_d;
  logic                 accept;
  logic                 base_ok;
  logic [WORD_SIZE-1:0] base_res;
  logic [SHW-1:0]       shamt;
  logic                 md_start, md_fast, md_done;
  logic [WORD_SIZE-1:0] md_fast_res, md_res;

  assign in_ready  = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q == S_ITER);
  assign shamt     = source2[SHW-1:0];

  always_comb begin
    base_res = '0;
    base_ok  = (funct7 == 7'b0000000) ||
               (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
    case (funct3)
      3'b000: base_res = funct7[5] ? source1 - source2 : source1 + source2;
      3'b001: base_res = source1 << shamt;
      3'b010: base_res = {{(WORD_SIZE-1){1'b0}}, ($signed(source1) < $signed(source2))};
      3'b011: base_res = {{(WORD_SIZE-1){1'b0}}, (source1 < source2)};
      3'b100: base_res = source1 ^ source2;
      3'b101: base_res = funct7[5] ? WORD_SIZE'($signed(source1) >>> shamt) : source1 >> shamt;
      3'b110: base_res = source1 | source2;
      3'b111: base_res = source1 & source2;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (md_start) begin
            state_d     = S_ITER;
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            illegal_d   = !(base_ok || md_fast);
            result_d    = base_ok ? base_res : (md_fast ? md_fast_res : '0);
          end
        end else if (out_valid_q) begin
          if (out_ready) out_valid_d = 1'b0;
          else           state_d     = S_HOLD;
        end
      end
      S_ITER: begin
        if (md_done) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          illegal_d   = 1'b0;
          result_d    = md_res;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef ALU_MDU_MULDIV_EN
  localparam logic [WORD_SIZE-1:0] MOST_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};

  logic [WORD_SIZE-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             op_q, op_d;
  logic                   neg_p_q, neg_p_d, neg_a_q, neg_a_d;
  logic                   md_sel, a_neg, b_neg;
  logic [WORD_SIZE-1:0]   a_mag, b_mag, step_hi, step_lo, quo, rem;
  logic [WORD_SIZE:0]     mul_sum, rem_sh;
  logic [2*WORD_SIZE-1:0] prod;

  assign md_sel  = (funct7 == 7'b0000001);
  assign md_done = (state_q == S_ITER) && (cnt_q == CW'(1));

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    a_neg       = source1[WORD_SIZE-1] && (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    b_neg       = source2[WORD_SIZE-1] && (funct3 inside {3'b001, 3'b100, 3'b110});
    a_mag       = a_neg ? -source1 : source1;
    b_mag       = b_neg ? -source2 : source2;
    md_fast     = 1'b0;
    md_fast_res = '0;
    if (md_sel && funct3[2]) begin
      if (source2 == '0) begin
        md_fast     = 1'b1;
        md_fast_res = funct3[1] ? source1 : '1;
      end else if (!funct3[0] && source1 == MOST_NEG && source2 == '1) begin
        md_fast     = 1'b1;
        md_fast_res = funct3[1] ? '0 : source1;
      end
    end
    md_start = md_sel && !md_fast;
  end

  // One shift-add or restoring-subtract step; the last step also applies sign fix-up.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    rem_sh  = {hi_q, lo_q[WORD_SIZE-1]};
    if (!op_q[2]) begin
      step_hi = mul_sum[WORD_SIZE:1];
      step_lo = {mul_sum[0], lo_q[WORD_SIZE-1:1]};
    end else if (rem_sh >= {1'b0, opb_q}) begin
      step_hi = WORD_SIZE'(rem_sh - {1'b0, opb_q});
      step_lo = {lo_q[WORD_SIZE-2:0], 1'b1};
    end else begin
      step_hi = rem_sh[WORD_SIZE-1:0];
      step_lo = {lo_q[WORD_SIZE-2:0], 1'b0};
    end
    prod = neg_p_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    quo  = neg_p_q ? -step_lo : step_lo;
    rem  = neg_a_q ? -step_hi : step_hi;
    case (op_q)
      3'b000:                 md_res = prod[WORD_SIZE-1:0];
      3'b001, 3'b010, 3'b011: md_res = prod[2*WORD_SIZE-1:WORD_SIZE];
      3'b100, 3'b101:         md_res = quo;
      default:                md_res = rem;
    endcase
  end

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_p_d = neg_p_q;
    neg_a_d = neg_a_q;
    if (accept && md_start) begin
      hi_d    = '0;
      lo_d    = funct3[2] ? a_mag : b_mag;
      opb_d   = funct3[2] ? b_mag : a_mag;
      cnt_d   = CW'(WORD_SIZE);
      op_d    = funct3;
      neg_p_d = a_neg ^ b_neg;
      neg_a_d = a_neg;
    end else if (state_q == S_ITER) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_p_q <= 1'b0;
      neg_a_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_p_q <= neg_p_d;
      neg_a_q <= neg_a_d;
    end
  end
`else
  assign md_start    = 1'b0;
  assign md_fast     = 1'b0;
  assign md_fast_res = '0;
  assign md_done     = 1'b0;
  assign md_res      = '0;
`endif

endmodule
